// File: rtl/monkey_action_ctrl_if.sv
// Signal bundle between the keyboard decoder / movement block and the monkey action sequencer.
// The sequencer uses the slave modport; the surrounding environment uses the master modport.
interface monkey_action_ctrl_if;
  logic               startOfFrame;
  logic               leftPressed;
  logic               rightPressed;
  logic               upPressed;
  logic               downPressed;
  logic               onRope;
  logic               onLedge;
  logic               collision;
  logic               hitEnemy;
  logic               restart;
  logic signed [10:0] topLeftY;
  logic               moveLeft;
  logic               moveRight;
  logic               moveUp;
  logic               moveDown;
  logic               moveResetN;
  logic [2:0]         actionState;
  logic [1:0]         livesLeft;
  logic               gameOver;

  modport slave (
    input  startOfFrame, leftPressed, rightPressed, upPressed, downPressed,
           onRope, onLedge, collision, hitEnemy, restart, topLeftY,
    output moveLeft, moveRight, moveUp, moveDown, moveResetN,
           actionState, livesLeft, gameOver
  );

  modport master (
    output startOfFrame, leftPressed, rightPressed, upPressed, downPressed,
           onRope, onLedge, collision, hitEnemy, restart, topLeftY,
    input  moveLeft, moveRight, moveUp, moveDown, moveResetN,
           actionState, livesLeft, gameOver
  );
endinterface

// File: rtl/monkey_action_ctrl.sv
// Frame-rate action sequencer for the player monkey: tracks action state and lives,
// gates key commands to the movement block and strobes its re-initialisation on respawn.
module monkey_action_ctrl #(
  parameter int JUMP_FRAMES   = 12,
  parameter int HIT_FRAMES    = 30,
  parameter int INITIAL_LIVES = 3,
  parameter int DEATH_Y       = 440
) (
  input  logic                 clk,
  input  logic                 resetN,
  monkey_action_ctrl_if.slave  bus
);

  localparam int JW = $clog2(JUMP_FRAMES + 1);
  localparam int HW = $clog2(HIT_FRAMES + 1);
  localparam logic [JW-1:0] JUMP_LOAD = JW'(JUMP_FRAMES - 1);
  localparam logic [HW-1:0] HIT_LOAD  = HW'(HIT_FRAMES - 1);
  localparam logic [1:0]    LIVES_INIT = 2'(INITIAL_LIVES);
  localparam logic signed [10:0] DEATH_LIMIT = 11'(DEATH_Y);

  typedef enum logic [2:0] {
    GROUND  = 3'd0,
    JUMP    = 3'd1,
    FALL    = 3'd2,
    CLIMB   = 3'd3,
    HIT     = 3'd4,
    RESPAWN = 3'd5,
    OVER    = 3'd6,
    ILLEGAL = 3'd7
  } state_t;

  state_t          state, stateNext;
  logic [JW-1:0]   jumpCnt, jumpNext;
  logic [HW-1:0]   hitCnt, hitNext;
  logic [1:0]      livesLeft, livesNext;
  logic            upPrev, upLatch, hitLatch;
  logic            upNow, hitNow, standing, dead;
  logic            moveLeft, moveRight, moveUp, moveDown, moveResetN, gameOver;
  logic            moveLeftNext, moveRightNext, moveUpNext, moveDownNext;
  logic            moveResetNNext, gameOverNext, lateralOk;

  // An event arriving on the consuming frame edge still counts for that frame.
  assign upNow    = upLatch | (bus.upPressed & ~upPrev);
  assign hitNow   = hitLatch | bus.hitEnemy;
  assign standing = bus.onLedge & bus.collision;
  assign dead     = hitNow | ($signed(bus.topLeftY) > DEATH_LIMIT);

  // Event latches: capture up-key rising edges and enemy hits between frame edges.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      upPrev   <= 1'b0;
      upLatch  <= 1'b0;
      hitLatch <= 1'b0;
    end else begin
      upPrev <= bus.upPressed;
      if (bus.startOfFrame) begin
        upLatch  <= 1'b0;
        hitLatch <= 1'b0;
      end else begin
        upLatch  <= upNow;
        hitLatch <= hitNow;
      end
    end
  end

  // Next-state, counter and lives logic, evaluated only on frame edges.
  always_comb begin
    stateNext = state;
    jumpNext  = jumpCnt;
    hitNext   = hitCnt;
    livesNext = livesLeft;
    if (bus.startOfFrame) begin
      case (state)
        GROUND, JUMP, FALL, CLIMB: begin
          if (dead) begin
            stateNext = HIT;
            hitNext   = HIT_LOAD;
            livesNext = (livesLeft == 2'd0) ? 2'd0 : livesLeft - 2'd1;
          end else begin
            case (state)
              GROUND: begin
                if (upNow) begin
                  stateNext = JUMP;
                  jumpNext  = JUMP_LOAD;
                end else if (bus.onRope) begin
                  stateNext = CLIMB;
                end else if (!standing) begin
                  stateNext = FALL;
                end else begin
                  stateNext = GROUND;
                end
              end
              JUMP: begin
                if (bus.onRope) begin
                  stateNext = CLIMB;
                end else if (jumpCnt == JW'(0)) begin
                  stateNext = FALL;
                end else begin
                  jumpNext = jumpCnt - JW'(1);
                end
              end
              FALL: begin
                if (bus.onRope) begin
                  stateNext = CLIMB;
                end else if (standing) begin
                  stateNext = GROUND;
                end else begin
                  stateNext = FALL;
                end
              end
              CLIMB: begin
                if (!bus.onRope) begin
                  stateNext = standing ? GROUND : FALL;
                end else begin
                  stateNext = CLIMB;
                end
              end
              default: stateNext = GROUND;
            endcase
          end
        end
        HIT: begin
          if (hitCnt == HW'(0)) begin
            stateNext = (livesLeft == 2'd0) ? OVER : RESPAWN;
          end else begin
            hitNext = hitCnt - HW'(1);
          end
        end
        RESPAWN: stateNext = GROUND;
        OVER: begin
          if (bus.restart) begin
            stateNext = RESPAWN;
            livesNext = LIVES_INIT;
          end else begin
            stateNext = OVER;
          end
        end
        default: stateNext = GROUND;
      endcase
    end else begin
      stateNext = state;
    end
  end

  // Command gating is computed against the next state so it lines up with actionState.
  always_comb begin
    lateralOk      = (stateNext == GROUND) || (stateNext == JUMP) || (stateNext == FALL);
    moveLeftNext   = lateralOk & bus.leftPressed;
    moveRightNext  = lateralOk & bus.rightPressed;
    moveDownNext   = (stateNext == CLIMB) & bus.downPressed;
    if (stateNext == CLIMB) begin
      moveUpNext = bus.upPressed;
    end else if (stateNext == GROUND) begin
      moveUpNext = upNow & ~bus.startOfFrame;
    end else begin
      moveUpNext = 1'b0;
    end
    moveResetNNext = (stateNext != RESPAWN);
    gameOverNext   = (stateNext == OVER);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= GROUND;
      jumpCnt    <= JW'(0);
      hitCnt     <= HW'(0);
      livesLeft  <= LIVES_INIT;
      moveLeft   <= 1'b0;
      moveRight  <= 1'b0;
      moveUp     <= 1'b0;
      moveDown   <= 1'b0;
      moveResetN <= 1'b1;
      gameOver   <= 1'b0;
    end else begin
      state      <= stateNext;
      jumpCnt    <= jumpNext;
      hitCnt     <= hitNext;
      livesLeft  <= livesNext;
      moveLeft   <= moveLeftNext;
      moveRight  <= moveRightNext;
      moveUp     <= moveUpNext;
      moveDown   <= moveDownNext;
      moveResetN <= moveResetNNext;
      gameOver   <= gameOverNext;
    end
  end

  assign bus.moveLeft    = moveLeft;
  assign bus.moveRight   = moveRight;
  assign bus.moveUp      = moveUp;
  assign bus.moveDown    = moveDown;
  assign bus.moveResetN  = moveResetN;
  assign bus.actionState = state;
  assign bus.livesLeft   = livesLeft;
  assign bus.gameOver    = gameOver;

endmodule

// File: tb/tb_monkey_action_ctrl.sv
// Directed, table-driven bench for monkey_action_ctrl; each vector holds levels, pulses,
// a frame count and the hand-computed outputs expected after those frames.
module tb_monkey_action_ctrl;

  logic clk;
  logic resetN;
  int   nVec;
  int   nMis;

  monkey_action_ctrl_if bus ();

  monkey_action_ctrl #(
    .JUMP_FRAMES(12), .HIT_FRAMES(30), .INITIAL_LIVES(3), .DEATH_Y(440)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]         in;   // {left,right,down,rope,ledge,coll,upPulse,hitPulse,restart}
    logic signed [10:0] y;
    int                 nf;
    logic [2:0]         st;
    logic [1:0]         lv;
    logic [5:0]         ex;   // {moveLeft,moveRight,moveUp,moveDown,moveResetN,gameOver}
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [8:0] in, input logic signed [10:0] y, input int nf,
                     input logic [2:0] st, input logic [1:0] lv, input logic [5:0] ex);
    vec_t v;
    v.in = in; v.y = y; v.nf = nf; v.st = st; v.lv = lv; v.ex = ex;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [10:0] act, input logic [10:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic chkAll(input int idx, input logic [2:0] st, input logic [1:0] lv, input logic [5:0] ex);
    chk("actionState", idx, 11'(bus.actionState), 11'(st));
    chk("livesLeft",   idx, 11'(bus.livesLeft),   11'(lv));
    chk("moveLeft",    idx, 11'(bus.moveLeft),    11'(ex[5]));
    chk("moveRight",   idx, 11'(bus.moveRight),   11'(ex[4]));
    chk("moveUp",      idx, 11'(bus.moveUp),      11'(ex[3]));
    chk("moveDown",    idx, 11'(bus.moveDown),    11'(ex[2]));
    chk("moveResetN",  idx, 11'(bus.moveResetN),  11'(ex[1]));
    chk("gameOver",    idx, 11'(bus.gameOver),    11'(ex[0]));
  endtask

  // One frame: startOfFrame for one clk (optionally with hitEnemy on that same clk), then idle.
  task automatic frame(input logic hitAtSof);
    @(negedge clk);
    bus.startOfFrame = 1'b1;
    bus.hitEnemy     = hitAtSof;
    @(negedge clk);
    bus.startOfFrame = 1'b0;
    bus.hitEnemy     = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulseUp();
    @(negedge clk); bus.upPressed = 1'b1;
    @(negedge clk); bus.upPressed = 1'b0;
  endtask

  task automatic pulseHit();
    @(negedge clk); bus.hitEnemy = 1'b1;
    @(negedge clk); bus.hitEnemy = 1'b0;
  endtask

  task automatic resetPulse(input int idx);
    @(negedge clk);
    resetN = 1'b0;
    #1;
    chkAll(idx, 3'd0, 2'd3, 6'b000010);
    @(negedge clk);
    resetN = 1'b1;
  endtask

  initial begin
    nVec = 0;
    nMis = 0;
    resetN = 1'b0;
    bus.startOfFrame = 1'b0; bus.leftPressed = 1'b0; bus.rightPressed = 1'b0;
    bus.upPressed = 1'b0; bus.downPressed = 1'b0; bus.onRope = 1'b0;
    bus.onLedge = 1'b1; bus.collision = 1'b1; bus.hitEnemy = 1'b0;
    bus.restart = 1'b0; bus.topLeftY = 11'sd100;

    //   in            y        nf  st    lv    ex
    add(9'b000011000, 11'sd100,  3, 3'd0, 2'd3, 6'b000010); // idle standing
    add(9'b010011000, 11'sd100,  1, 3'd0, 2'd3, 6'b010010); // right in GROUND
    add(9'b110011000, 11'sd100,  1, 3'd0, 2'd3, 6'b110010); // both keys pass
    add(9'b000011100, 11'sd100,  1, 3'd1, 2'd3, 6'b000010); // up pulse -> JUMP
    add(9'b000000000, 11'sd100, 11, 3'd1, 2'd3, 6'b000010); // still JUMP
    add(9'b000000000, 11'sd100,  1, 3'd2, 2'd3, 6'b000010); // 12th frame -> FALL
    add(9'b010000000, 11'sd100,  1, 3'd2, 2'd3, 6'b010010); // right in FALL
    add(9'b011100000, 11'sd100,  1, 3'd3, 2'd3, 6'b000110); // rope -> CLIMB
    add(9'b000011000, 11'sd100,  1, 3'd0, 2'd3, 6'b000010); // off rope, standing
    add(9'b000011010, 11'sd100,  1, 3'd4, 2'd2, 6'b000010); // hit -> HIT
    add(9'b000011000, 11'sd100, 29, 3'd4, 2'd2, 6'b000010);
    add(9'b000011000, 11'sd100,  1, 3'd5, 2'd2, 6'b000000); // RESPAWN
    add(9'b000011000, 11'sd100,  1, 3'd0, 2'd2, 6'b000010);
    add(9'b000011000, 11'sd450,  1, 3'd4, 2'd1, 6'b000010); // fall-off death
    add(9'b000011000, 11'sd100, 30, 3'd5, 2'd1, 6'b000000);
    add(9'b000011000, 11'sd100,  1, 3'd0, 2'd1, 6'b000010);
    add(9'b000011000, 11'sd450,  1, 3'd4, 2'd0, 6'b000010);
    add(9'b000011000, 11'sd100, 30, 3'd6, 2'd0, 6'b000011); // OVER
    add(9'b000011000, 11'sd100,  2, 3'd6, 2'd0, 6'b000011);
    add(9'b000011001, 11'sd100,  1, 3'd5, 2'd3, 6'b000000); // restart
    add(9'b000011000, 11'sd100,  1, 3'd0, 2'd3, 6'b000010);
    add(9'b000011000, 11'sd440,  1, 3'd0, 2'd3, 6'b000010); // boundary not dead
    add(9'b000011000, -11'sd5,   1, 3'd0, 2'd3, 6'b000010); // signed compare
    add(9'b000011000, 11'sd441,  1, 3'd4, 2'd2, 6'b000010);
    add(9'b000011000, 11'sd100,  5, 3'd4, 2'd2, 6'b000010); // mid-HIT

    repeat (2) @(negedge clk);
    chkAll(100, 3'd0, 2'd3, 6'b000010);
    resetN = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      {bus.leftPressed, bus.rightPressed, bus.downPressed, bus.onRope,
       bus.onLedge, bus.collision} = vecs[i].in[8:3];
      bus.restart  = vecs[i].in[0];
      bus.topLeftY = vecs[i].y;
      if (vecs[i].in[2]) pulseUp();
      if (vecs[i].in[1]) pulseHit();
      for (int f = 0; f < vecs[i].nf; f++) frame(1'b0);
      chkAll(i, vecs[i].st, vecs[i].lv, vecs[i].ex);
    end

    // Reset in mid-HIT with a freshly latched hit: nothing may carry over.
    pulseHit();
    resetPulse(200);
    frame(1'b0);
    chkAll(201, 3'd0, 2'd3, 6'b000010);

    // Up impulse: moveUp high from the rise until the consuming frame edge.
    pulseUp();
    chk("moveUpImpulse", 202, 11'(bus.moveUp), 11'd1);
    repeat (2) @(negedge clk);
    chk("moveUpHold", 203, 11'(bus.moveUp), 11'd1);
    frame(1'b0);
    chkAll(204, 3'd1, 2'd3, 6'b000010);

    // Hit arriving on the startOfFrame clk itself still counts this frame.
    frame(1'b1);
    chkAll(205, 3'd4, 2'd2, 6'b000010);

    // Up and hit in the same frame: death wins.
    resetPulse(206);
    frame(1'b0);
    pulseUp();
    pulseHit();
    frame(1'b0);
    chkAll(207, 3'd4, 2'd2, 6'b000010);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule

// File: doc/monkey_action_ctrl.md
# monkey_action_ctrl

Frame-rate action sequencer for the player monkey. It sits between the keyboard decoder and the monkey movement/collision block, and tracks the monkey's action state: ground, jump, fall, climb, hit, respawn, game over. It gates which key commands reach the movement datapath, shapes the jump key into a single-frame impulse, and counts lives. When the monkey is hit or falls off screen, it drives a re-initialisation strobe to the movement block.

## Interface
- JUMP_FRAMES, 12: frames the JUMP state lasts before ledge contact is honoured again
- HIT_FRAMES, 30: frames spent frozen in HIT
- INITIAL_LIVES, 3: lives loaded at reset and restart (1..3)
- DEATH_Y, 440: topLeftY strictly above this value counts as fall-off death

- clk  in  1  system clock
- resetN  in  1  asynchronous, active-low reset
- startOfFrame  in  1  one-clk pulse per video frame
- leftPressed, rightPressed, upPressed, downPressed  in  1 each  raw key levels
- onRope  in  1  monkey overlaps a rope
- onLedge  in  1  monkey overlaps a ledge
- collision  in  1  monkey pixel collision qualifier
- hitEnemy  in  1  per-pixel enemy contact, may pulse any cycle
- restart  in  1  new-game request, honoured only in OVER
- topLeftY  in  11 signed  monkey vertical position from movement block
- moveLeft, moveRight, moveUp, moveDown  out  1 each  gated commands to movement block
- moveResetN  out  1  active-low re-init strobe to movement block
- actionState  out  3  current state code
- livesLeft  out  2  remaining lives
- gameOver  out  1  high while in OVER

## Operation
- State codes: GROUND=0, JUMP=1, FALL=2, CLIMB=3, HIT=4, RESPAWN=5, OVER=6. Code 7 is illegal and recovers to GROUND on the next startOfFrame.
- Derived signals: standing = onLedge & collision; dead = hitLatch | (topLeftY > DEATH_Y), signed compare.
- Event latches:
  - hitLatch sets on any clk with hitEnemy=1.
  - upLatch sets on a rising edge of upPressed (previous-sample register).
  - Both clear on the clk where startOfFrame=1, after being used. A set and a clear in the same clk: clear wins, and the event counts for this frame.
- Transitions are evaluated only on clk edges with startOfFrame=1. Priority is top to bottom:
  - GROUND/JUMP/FALL/CLIMB: dead -> HIT. On entry, livesLeft decrements (saturating at 0) and hitCnt loads HIT_FRAMES-1.
  - GROUND: upLatch -> JUMP (jumpCnt loads JUMP_FRAMES-1); else onRope -> CLIMB; else !standing -> FALL.
  - JUMP: onRope -> CLIMB; else jumpCnt==0 -> FALL; else jumpCnt decrements. Ledge contact is ignored.
  - FALL: onRope -> CLIMB; else standing -> GROUND.
  - CLIMB: !onRope & standing -> GROUND; !onRope & !standing -> FALL.
  - HIT: hitCnt==0 -> OVER if livesLeft==0, else RESPAWN; otherwise decrement.
  - RESPAWN: -> GROUND unconditionally.
  - OVER: restart=1 on the evaluation edge -> RESPAWN, with livesLeft reloaded to INITIAL_LIVES.
- Command gating (registered):
  - moveLeft/moveRight = key level in GROUND, JUMP, FALL; 0 otherwise. If both keys are pressed, both pass; the movement block resolves it.
  - moveUp: in CLIMB, equals upPressed. In GROUND, asserted from the cycle after upLatch sets through the startOfFrame edge that consumes it (a one-frame impulse). 0 otherwise.
  - moveDown = downPressed in CLIMB only.
- moveResetN = 0 for exactly the cycles while state==RESPAWN, 1 otherwise.
- gameOver = (state==OVER).

## Timing
- Reset values:
  - state GROUND; livesLeft INITIAL_LIVES.
  - All move* outputs 0; moveResetN 1; gameOver 0.
  - jumpCnt, hitCnt, and both latches 0.
- All outputs are registered; there are no combinational input-to-output paths.
- A state change is visible one clk after the startOfFrame edge. Gated commands follow key levels with a one-clk latency.
- RESPAWN lasts exactly one frame period. The movement block is therefore held at its initial position for one full frame.
- A dead event and a restart/upLatch in the same frame: dead wins.
- An asserted resetN mid-frame returns everything to reset values immediately. Latches do not carry over.

## Test plan
- Reset, then standing=1 and 3 frames idle -> actionState=0, livesLeft=3, all move*=0, moveResetN=1.
- In GROUND, pulse upPressed for 1 clk mid-frame -> moveUp high until the next startOfFrame, then low. actionState=1 for 12 frames, then 2 (standing=0). Asserting standing later gives 0.
- In FALL, onRope=1 at a frame edge -> actionState=3. Then downPressed -> moveDown=1. rightPressed -> moveRight stays 0.
- In GROUND, a 1-clk hitEnemy pulse -> next frame actionState=4 and livesLeft=2. After 30 frames, actionState=5 with moveResetN=0 for one frame, then 0.
- Three hits, or topLeftY=450 three times -> livesLeft=0, actionState=6, gameOver=1. Restart at a frame edge -> actionState=5, livesLeft=3.
- Assert resetN low while in HIT with hitCnt mid-count -> outputs return to reset values immediately, and there is no pending hit after release.
